// File: rtl/bcd_disp_pkg.sv
// Shared types, 7-segment glyphs and helpers for the BCD display driver.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_ndigit_seq_if.sv
// Handshake and display bundle between the converter and its user.
// master drives the binary value, slave returns the decoded result.
interface bcd_ndigit_seq_if #(
    parameter int N_IN  = 10,
    parameter int N_DIG = 4
);
    logic                 in_valid;
    logic [N_IN-1:0]      bin_in;
    logic                 in_ready;
    logic                 out_valid;
    logic                 overflow;
    logic [4*N_DIG-1:0]   bcd_out;
    logic [7*N_DIG-1:0]   seg_out;

    modport master (
        output in_valid,
        output bin_in,
        input  in_ready,
        input  out_valid,
        input  overflow,
        input  bcd_out,
        input  seg_out
    );

    modport slave (
        input  in_valid,
        input  bin_in,
        output in_ready,
        output out_valid,
        output overflow,
        output bcd_out,
        output seg_out
    );

endinterface

// File: rtl/seg7_digit_dec.sv
// One digit of 7-segment decode: nibble + blank + overflow to a pattern.
// Overflow wins over blanking; nibbles above 9 render as a dash.
module seg7_digit_dec
    import bcd_disp_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       ovf,
    output logic [6:0] seg
);

    logic [6:0] glyph;
    logic [6:0] raw;

    always_comb begin
        glyph = SEG_DASH;
        case (nib)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

    always_comb begin
        raw = glyph;
        unique case (1'b1)
            ovf:            raw = SEG_DASH;
            (blank & ~ovf): raw = SEG_OFF;
            default:        raw = glyph;
        endcase
        seg = SEG_ACT_LOW ? ~raw : raw;
    end

endmodule

// File: rtl/bcd_ndigit_seq.sv
// Sequential N-digit binary-to-BCD converter (double-dabble, one bit
// per clock) with registered BCD and 7-segment outputs.
module bcd_ndigit_seq
    import bcd_disp_pkg::*;
#(
    parameter int N_IN        = 10,
    parameter int N_DIG       = 4,
    parameter bit LZ_BLANK    = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input logic          clk,
    input logic          rst,
    bcd_ndigit_seq_if.slave io
);

    localparam int W  = 4 * N_DIG;
    localparam int SW = W + N_IN;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CW-1:0] LAST    = CW'(N_IN - 1);
    localparam logic [63:0]   LIMIT   = pow10(N_DIG) - 64'd1;
    localparam logic [6:0]    OFF_PAT = SEG_ACT_LOW ? 7'h7F : 7'h00;

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       cnt_q;
    logic [SW-1:0]       sr_q;
    logic                ovf_q;
    logic [W-1:0]        bcd_q;
    logic [7*N_DIG-1:0]  seg_q;
    logic                ovf_out_q;

    logic [W-1:0]        bcd_adj;
    logic [SW-1:0]       sr_shl;
    logic [W-1:0]        bcd_fin;
    logic [N_DIG-1:0]    blank;
    logic [7*N_DIG-1:0]  seg_d;
    logic                nz;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io.in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Add-3 correction on every nibble, then shift {bcd,bin} left by one.
    always_comb begin
        bcd_adj = sr_q[SW-1:N_IN];
        for (int k = 0; k < N_DIG; k++) begin
            if (sr_q[N_IN+4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = sr_q[N_IN+4*k +: 4] + 4'd3;
            end
        end
        sr_shl = {bcd_adj, sr_q[N_IN-1:0]} << 1;
    end

    assign bcd_fin = sr_shl[SW-1:N_IN];

    // A digit above the units is blank while it and every higher digit are 0.
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            nz       = nz | (bcd_fin[4*k +: 4] != 4'd0);
            blank[k] = LZ_BLANK && (k != 0) && !nz && !ovf_q;
        end
    end

    for (genvar g = 0; g < N_DIG; g++) begin : g_dec
        seg7_digit_dec #(
            .SEG_ACT_LOW(SEG_ACT_LOW)
        ) u_dec (
            .nib  (bcd_fin[4*g +: 4]),
            .blank(blank[g]),
            .ovf  (ovf_q),
            .seg  (seg_d[7*g +: 7])
        );
    end

    // Output registers load on the final shift so they are valid in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= {N_DIG{OFF_PAT}};
            ovf_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        sr_q  <= {{W{1'b0}}, io.bin_in};
                        cnt_q <= '0;
                        ovf_q <= 64'(io.bin_in) > LIMIT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_shl;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        bcd_q     <= ovf_q ? {W{1'b1}} : bcd_fin;
                        seg_q     <= seg_d;
                        ovf_out_q <= ovf_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.overflow  = ovf_out_q;
    assign io.bcd_out   = bcd_q;
    assign io.seg_out   = seg_q;

endmodule
